// File: rtl/ts_event_sequencer.sv
// ts_event_sequencer: pops AER events, expands spikes into post-word sweeps and markers into update sweeps.
// Optional SEQ_EVT_CNT_EN adds a saturating per-sample spike counter on EVT_CNT.
module ts_event_sequencer #(
  parameter int TIME_STEP           = 8,
  parameter int OUTPUT_NEURON       = 256,
  parameter int POST_NEUR_PARALLEL  = 4,
  parameter int POST_WORD_CNT_WIDTH = 6,
  parameter int PRE_NEUR_ADDR_WIDTH = 10,
  parameter int AER_IN_CORE_WIDTH   = 12,
  parameter int TS_CNT_WIDTH        = 3
) (
  input  logic                           CLK,
  input  logic                           RSTN,
  input  logic                           START,
  input  logic                           SCHED_EMPTY,
  input  logic [AER_IN_CORE_WIDTH-1:0]   SCHED_DATA_OUT,
  output logic                           CTRL_SCHED_POP_N,
  output logic                           EVT_VALID,
  output logic [PRE_NEUR_ADDR_WIDTH-1:0] EVT_PRE_ADDR,
  output logic [POST_WORD_CNT_WIDTH-1:0] EVT_POST_WORD,
  output logic                           UPD_VALID,
  output logic [POST_WORD_CNT_WIDTH-1:0] UPD_POST_WORD,
  input  logic                           DP_READY,
  output logic [TS_CNT_WIDTH-1:0]        TS_IDX,
  output logic                           BUSY,
  output logic                           DONE
`ifdef SEQ_EVT_CNT_EN
  ,
  output logic [15:0]                    EVT_CNT
`endif
);
  localparam logic [POST_WORD_CNT_WIDTH-1:0] LAST_WORD =
    POST_WORD_CNT_WIDTH'(OUTPUT_NEURON / POST_NEUR_PARALLEL - 1);
  localparam logic [TS_CNT_WIDTH-1:0] LAST_TS = TS_CNT_WIDTH'(TIME_STEP - 1);
  typedef enum logic [2:0] {IDLE, WAIT_EVT, FETCH, SPK_SWEEP, UPD_SWEEP, FIN} state_t;
  state_t state_q, state_d;
  logic [PRE_NEUR_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [POST_WORD_CNT_WIDTH-1:0] word_q, word_d;
  logic [TS_CNT_WIDTH-1:0]        ts_q, ts_d;
  logic [1:0]                     virts;
  logic                           accept, last_acc;
  assign virts    = SCHED_DATA_OUT[AER_IN_CORE_WIDTH-1 -: 2];
  assign accept   = (EVT_VALID | UPD_VALID) & DP_READY;
  assign last_acc = accept & (word_q == LAST_WORD);
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) state_q <= IDLE;
    else       state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = START ? WAIT_EVT : IDLE;
      WAIT_EVT:  state_d = SCHED_EMPTY ? WAIT_EVT : FETCH;
      FETCH:     state_d = virts == 2'b00 ? SPK_SWEEP : virts == 2'b01 ? UPD_SWEEP : WAIT_EVT;
      SPK_SWEEP: state_d = last_acc ? WAIT_EVT : SPK_SWEEP;
      UPD_SWEEP: state_d = !last_acc ? UPD_SWEEP : ts_q == LAST_TS ? FIN : WAIT_EVT;
      default:   state_d = IDLE;
    endcase
  end
  always_comb begin
    CTRL_SCHED_POP_N = state_q != FETCH;
    EVT_VALID        = state_q == SPK_SWEEP;
    UPD_VALID        = state_q == UPD_SWEEP;
    BUSY             = state_q != IDLE;
    DONE             = state_q == FIN;
    EVT_PRE_ADDR     = addr_q;
    EVT_POST_WORD    = word_q;
    UPD_POST_WORD    = word_q;
    TS_IDX           = ts_q;
  end
  // The payload is captured on the same edge that pops it, so the sweep never reads a stale head.
  always_comb begin
    addr_d = (state_q == FETCH && virts == 2'b00) ? SCHED_DATA_OUT[PRE_NEUR_ADDR_WIDTH-1:0] : addr_q;
    word_d = state_q == FETCH ? '0 : accept ? word_q + POST_WORD_CNT_WIDTH'(1) : word_q;
    ts_d   = (state_q == IDLE && START) ? '0 :
             (state_q == UPD_SWEEP && last_acc) ? (ts_q == LAST_TS ? '0 : ts_q + TS_CNT_WIDTH'(1)) : ts_q;
  end
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      addr_q <= '0;
      word_q <= '0;
      ts_q   <= '0;
    end else begin
      addr_q <= addr_d;
      word_q <= word_d;
      ts_q   <= ts_d;
    end
`ifdef SEQ_EVT_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  always_comb
    cnt_d = (state_q == IDLE && START) ? 16'd0 :
            (state_q == FETCH && virts == 2'b00 && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  assign EVT_CNT = cnt_q;
`endif
endmodule

// File: tb/tb_ts_event_sequencer.sv
// tb_ts_event_sequencer: directed bench with a behavioural show-ahead FIFO and beat/pop monitors.
module tb_ts_event_sequencer;
  logic        CLK = 0, RSTN = 0, START = 0, DP_READY = 1, flush = 0;
  logic        SCHED_EMPTY, CTRL_SCHED_POP_N, EVT_VALID, UPD_VALID, BUSY, DONE;
  logic [11:0] SCHED_DATA_OUT;
  logic [9:0]  EVT_PRE_ADDR;
  logic [5:0]  EVT_POST_WORD, UPD_POST_WORD;
  logic [2:0]  TS_IDX;
`ifdef SEQ_EVT_CNT_EN
  logic [15:0] EVT_CNT;
`endif
  logic [11:0] mem [0:255];
  logic [7:0]  wr = 0, rd = 0;
  int pops = 0, evt_acc = 0, upd_acc = 0, both = 0, dones = 0, nsw = 0;
  logic [9:0]  alog [0:63];
  int n_chk = 0, n_fail = 0;
  int p0, e0, u0, s0, d0;

  ts_event_sequencer dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .SCHED_EMPTY(SCHED_EMPTY),
    .SCHED_DATA_OUT(SCHED_DATA_OUT), .CTRL_SCHED_POP_N(CTRL_SCHED_POP_N),
    .EVT_VALID(EVT_VALID), .EVT_PRE_ADDR(EVT_PRE_ADDR), .EVT_POST_WORD(EVT_POST_WORD),
    .UPD_VALID(UPD_VALID), .UPD_POST_WORD(UPD_POST_WORD), .DP_READY(DP_READY),
    .TS_IDX(TS_IDX), .BUSY(BUSY), .DONE(DONE)
`ifdef SEQ_EVT_CNT_EN
    , .EVT_CNT(EVT_CNT)
`endif
  );

  always #5 CLK = ~CLK;
  assign SCHED_EMPTY    = (rd == wr);
  assign SCHED_DATA_OUT = mem[rd];

  always @(posedge CLK) begin
    if (flush) rd <= wr;
    else if (!CTRL_SCHED_POP_N) begin
      rd <= rd + 8'd1;
      pops <= pops + 1;
    end
    if (EVT_VALID && DP_READY) evt_acc <= evt_acc + 1;
    if (UPD_VALID && DP_READY) upd_acc <= upd_acc + 1;
    if (EVT_VALID && UPD_VALID) both <= both + 1;
    if (DONE) dones <= dones + 1;
    if (EVT_VALID && DP_READY && EVT_POST_WORD == 6'd0) begin
      alog[nsw[5:0]] <= EVT_PRE_ADDR;
      nsw <= nsw + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] v, input logic [9:0] a);
    mem[wr] = {v, a};
    wr = wr + 8'd1;
  endtask

  task automatic pulse_start();
    START = 1;
    @(negedge CLK);
    START = 0;
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk("rst_pop_n", CTRL_SCHED_POP_N, 1);
    chk("rst_evt_valid", EVT_VALID, 0);
    chk("rst_upd_valid", UPD_VALID, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_ts", TS_IDX, 0);
    chk("rst_addr", EVT_PRE_ADDR, 0);
    chk("rst_words", {EVT_POST_WORD, UPD_POST_WORD}, 0);
    RSTN = 1;
    repeat (3) @(negedge CLK);
    chk("idle_no_pop", pops, 0);

    // three spikes then an end-of-step marker
    push(2'b00, 10'd5); push(2'b00, 10'd9); push(2'b00, 10'd783); push(2'b01, 10'd0);
    p0 = pops; e0 = evt_acc; u0 = upd_acc; s0 = nsw;
    pulse_start();
    chk("start_busy", BUSY, 1);
    chk("start_ts", TS_IDX, 0);
    for (int i = 0; i < 600 && !(upd_acc - u0 == 64 && !UPD_VALID); i++) @(negedge CLK);
    chk("t1_upd_beats", upd_acc - u0, 64);
    chk("t1_evt_beats", evt_acc - e0, 192);
    chk("t1_pops", pops - p0, 4);
    chk("t1_ts", TS_IDX, 1);
    chk("t1_addr0", alog[s0], 5);
    chk("t1_addr1", alog[s0 + 1], 9);
    chk("t1_addr2", alog[s0 + 2], 783);
    chk("t1_busy", BUSY, 1);

    // backpressure at word 17
    e0 = evt_acc;
    push(2'b00, 10'd42);
    for (int i = 0; i < 100 && !(EVT_VALID && EVT_POST_WORD == 6'd17); i++) @(negedge CLK);
    chk("bp_reach17", EVT_POST_WORD, 17);
    DP_READY = 0;
    repeat (10) @(negedge CLK);
    chk("bp_valid", EVT_VALID, 1);
    chk("bp_word", EVT_POST_WORD, 17);
    chk("bp_addr", EVT_PRE_ADDR, 42);
    DP_READY = 1;
    for (int i = 0; i < 100 && EVT_VALID; i++) @(negedge CLK);
    chk("bp_end", EVT_VALID, 0);
    chk("bp_beats", evt_acc - e0, 64);

    // dropped entry followed by a spike
    p0 = pops; e0 = evt_acc;
    push(2'b10, 10'd12); push(2'b00, 10'd3);
    @(negedge CLK);
    chk("drop_pop1", CTRL_SCHED_POP_N, 0);
    @(negedge CLK);
    chk("drop_nopop", CTRL_SCHED_POP_N, 1);
    chk("drop_novalid", {EVT_VALID, UPD_VALID}, 0);
    @(negedge CLK);
    chk("drop_pop2", CTRL_SCHED_POP_N, 0);
    @(negedge CLK);
    chk("drop_valid", EVT_VALID, 1);
    chk("drop_addr", EVT_PRE_ADDR, 3);
    chk("drop_word0", EVT_POST_WORD, 0);
    for (int i = 0; i < 100 && EVT_VALID; i++) @(negedge CLK);
    chk("drop_pops", pops - p0, 2);
    chk("drop_beats", evt_acc - e0, 64);
`ifdef SEQ_EVT_CNT_EN
    chk("drop_cnt", EVT_CNT, 5);
`endif

    // remaining seven markers finish the sample; an eighth is left behind
    p0 = pops; u0 = upd_acc; d0 = dones;
    for (int i = 0; i < 8; i++) push(2'b01, 10'd0);
    for (int i = 0; i < 1000 && BUSY; i++) @(negedge CLK);
    chk("fin_busy", BUSY, 0);
    chk("fin_done_low", DONE, 0);
    chk("fin_dones", dones - d0, 1);
    chk("fin_pops", pops - p0, 7);
    chk("fin_upd_beats", upd_acc - u0, 448);
    chk("fin_ts", TS_IDX, 0);
    repeat (5) @(negedge CLK);
    chk("fin_leftover", {SCHED_EMPTY, CTRL_SCHED_POP_N}, 2'b01);
    chk("fin_no_pop", pops - p0, 7);
`ifdef SEQ_EVT_CNT_EN
    chk("fin_cnt_hold", EVT_CNT, 5);
`endif

    // START with empty FIFO, then START mid-sweep
    flush = 1;
    @(negedge CLK);
    flush = 0;
    p0 = pops;
    pulse_start();
    chk("empty_busy", BUSY, 1);
    repeat (20) @(negedge CLK);
    chk("empty_no_pop", pops - p0, 0);
    chk("empty_pop_n", CTRL_SCHED_POP_N, 1);
    push(2'b00, 10'd100);
    for (int i = 0; i < 100 && !(EVT_VALID && EVT_POST_WORD == 6'd10); i++) @(negedge CLK);
    pulse_start();
    chk("mid_start_word", EVT_POST_WORD, 11);
    chk("mid_start_valid", EVT_VALID, 1);
    chk("mid_start_addr", EVT_PRE_ADDR, 100);
    chk("mid_start_ts", TS_IDX, 0);
`ifdef SEQ_EVT_CNT_EN
    chk("mid_start_cnt", EVT_CNT, 1);
`endif

    // asynchronous reset at word 30
    for (int i = 0; i < 100 && !(EVT_VALID && EVT_POST_WORD == 6'd30); i++) @(negedge CLK);
    chk("rst_reach30", EVT_POST_WORD, 30);
    RSTN = 0;
    #1;
    chk("mrst_valid", {EVT_VALID, UPD_VALID}, 0);
    chk("mrst_busy", BUSY, 0);
    chk("mrst_pop_n", CTRL_SCHED_POP_N, 1);
    chk("mrst_word", EVT_POST_WORD, 0);
    chk("mrst_addr", EVT_PRE_ADDR, 0);
    @(negedge CLK);
    push(2'b00, 10'd1);
    p0 = pops;
    RSTN = 1;
    repeat (10) @(negedge CLK);
    chk("post_rst_no_pop", pops - p0, 0);
    chk("post_rst_busy", BUSY, 0);
    chk("post_rst_valid", EVT_VALID, 0);
    chk("never_both_valid", both, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
